tb_wait_cmd_exec: RTL and testbench

- Testbench command executor sitting directly downstream of the scenario-file sequencer.
- Consumes the parsed argument strings and the one-cycle `args_valid` pulse.
- Executes the wait/synchronisation command family: clock-count waits, edge waits, edge waits with timeout, and no-ops.
- Returns the one-cycle `ack` that makes the sequencer fetch the next scenario line.

---
 rtl/tb_wait_cmd_exec.sv | 152 +++++++++++++++
 tb/tb_tb_wait_cmd_exec.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tb_wait_cmd_exec.sv
// Scenario-file command executor for the wait/synchronisation family:
// clock-count waits, edge waits (optionally with timeout) and no-ops.
module tb_wait_cmd_exec #(
  parameter int ARGS_NB = 5,
  parameter int EVT_NB  = 8,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  string             args [ARGS_NB],
  input  logic              args_valid,
  input  logic [EVT_NB-1:0] events,
  output logic              ack,
  output logic              busy,
  output logic              timeout_err,
  output logic              unknown_cmd,
  output logic [15:0]       err_cnt
);

  localparam int IDX_W = (EVT_NB > 1) ? $clog2(EVT_NB) : 1;

  typedef enum logic [1:0] {INIT, IDLE, WAIT_CLK, WAIT_EDGE} state_t;
  typedef enum logic [1:0] {CMD_UNKNOWN, CMD_NOP, CMD_WAIT, CMD_EDGE} cmd_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_rise;
  logic               r_useTo;
  logic [EVT_NB-1:0]  r_evtQ;

  cmd_t               w_cmd;
  logic               w_rise;
  logic               w_useTo;
  logic               w_idxOk;
  int                 w_arg1Int;
  int                 w_arg2Int;
  logic [CNT_W-1:0]   w_arg1;
  logic [CNT_W-1:0]   w_arg2;
  logic [IDX_W-1:0]   w_idx;
  logic               w_edgeHit;

  // Command decode; an out-of-range event index makes the command unknown.
  always_comb begin
    w_cmd     = CMD_UNKNOWN;
    w_rise    = 1'b0;
    w_useTo   = 1'b0;
    w_arg1Int = args[1].atoi();
    w_arg2Int = args[2].atoi();
    w_idxOk   = (w_arg1Int >= 0) && (w_arg1Int < EVT_NB);
    if (args[0] == "NOP" || args[0] == "END_TEST" || args[0] == "") begin
      w_cmd = CMD_NOP;
    end else if (args[0] == "WAIT_CLK") begin
      w_cmd = CMD_WAIT;
    end else if (w_idxOk && (args[0] == "WTR" || args[0] == "WTF" ||
                             args[0] == "WTRT" || args[0] == "WTFT")) begin
      w_cmd   = CMD_EDGE;
      w_rise  = (args[0] == "WTR") || (args[0] == "WTRT");
      w_useTo = (args[0] == "WTRT") || (args[0] == "WTFT");
    end
  end

  assign w_arg1 = CNT_W'(w_arg1Int);
  assign w_arg2 = CNT_W'(w_arg2Int);
  assign w_idx  = IDX_W'(w_arg1Int);

  assign w_edgeHit = r_rise ? (events[r_idx] & ~r_evtQ[r_idx])
                            : (~events[r_idx] & r_evtQ[r_idx]);

  // r_cnt counts down to 1 so that the registered ack lands exactly on time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= INIT;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rise      <= 1'b0;
      r_useTo     <= 1'b0;
      r_evtQ      <= '0;
      ack         <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      unknown_cmd <= 1'b0;
      err_cnt     <= '0;
    end else begin
      ack         <= 1'b0;
      timeout_err <= 1'b0;
      unknown_cmd <= 1'b0;
      r_evtQ      <= events;
      case (r_state)
        INIT: begin
          ack     <= 1'b1;
          r_state <= IDLE;
        end
        IDLE: begin
          if (args_valid) begin
            case (w_cmd)
              CMD_NOP: ack <= 1'b1;
              CMD_WAIT: begin
                if (w_arg1 <= CNT_W'(1)) begin
                  ack <= 1'b1;
                end else begin
                  r_cnt   <= w_arg1 - CNT_W'(1);
                  busy    <= 1'b1;
                  r_state <= WAIT_CLK;
                end
              end
              CMD_EDGE: begin
                r_idx   <= w_idx;
                r_rise  <= w_rise;
                r_useTo <= w_useTo;
                r_cnt   <= w_arg2;
                busy    <= 1'b1;
                r_state <= WAIT_EDGE;
              end
              default: begin
                ack         <= 1'b1;
                unknown_cmd <= 1'b1;
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
              end
            endcase
          end
        end
        WAIT_CLK: begin
          if (r_cnt <= CNT_W'(1)) begin
            ack     <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        WAIT_EDGE: begin
          if (w_edgeHit) begin
            ack     <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else if (r_useTo && r_cnt <= CNT_W'(1)) begin
            ack         <= 1'b1;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            r_state     <= IDLE;
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
          end else if (r_useTo) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_wait_cmd_exec.sv
// Directed bench for tb_wait_cmd_exec: each step drives one scenario line
// and checks the cycle-exact ack/busy/error response.
module tb_tb_wait_cmd_exec;

  logic        clk;
  logic        rst;
  string       args [5];
  logic        args_valid;
  logic [7:0]  events;
  logic        ack;
  logic        busy;
  logic        timeout_err;
  logic        unknown_cmd;
  logic [15:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  tb_wait_cmd_exec #(.ARGS_NB(5), .EVT_NB(8), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .args        (args),
    .args_valid  (args_valid),
    .events      (events),
    .ack         (ack),
    .busy        (busy),
    .timeout_err (timeout_err),
    .unknown_cmd (unknown_cmd),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one command for a single cycle (cycle T); returns in cycle T+1.
  task automatic applyStimulus(input string a0, input string a1, input string a2);
    args[0] = a0;
    args[1] = a1;
    args[2] = a2;
    args_valid = 1'b1;
    tick();
    args_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    args_valid = 1'b0;
    events = 8'h00;
    foreach (args[i]) args[i] = "";
    tick();
    tick();
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err_cnt, 0);
    rst = 1'b0;
    checkOutput("rel_noack", ack, 0);
    tick();
    checkOutput("boot_ack", ack, 1);
    checkOutput("boot_busy", busy, 0);
    tick();
    checkOutput("boot_ack_single", ack, 0);

    $display("[TB] WAIT_CLK 10");
    applyStimulus("WAIT_CLK", "10", "");
    for (int k = 1; k < 10; k++) begin
      checkOutput("wclk_busy", busy, 1);
      checkOutput("wclk_noack", ack, 0);
      tick();
    end
    checkOutput("wclk_ack", ack, 1);
    checkOutput("wclk_busy_end", busy, 0);
    tick();
    checkOutput("wclk_ack_single", ack, 0);

    applyStimulus("WAIT_CLK", "0", "");
    checkOutput("wclk0_ack", ack, 1);
    checkOutput("wclk0_busy", busy, 0);
    tick();

    $display("[TB] WTR 3");
    events[3] = 1'b1;
    applyStimulus("WTR", "3", "");
    checkOutput("wtr_coinc_noack", ack, 0);
    checkOutput("wtr_busy", busy, 1);
    events[3] = 1'b0;
    tick();
    checkOutput("wtr_fall_noack", ack, 0);
    events[2] = 1'b1;
    tick();
    checkOutput("wtr_ev2_noack", ack, 0);
    events[2] = 1'b0;
    for (int k = 0; k < 22; k++) tick();
    checkOutput("wtr_pre_noack", ack, 0);
    checkOutput("wtr_pre_busy", busy, 1);
    events[3] = 1'b1;
    tick();
    checkOutput("wtr_ack", ack, 1);
    checkOutput("wtr_busy_end", busy, 0);
    tick();
    checkOutput("wtr_ack_single", ack, 0);
    events[3] = 1'b0;

    $display("[TB] WTFT 1 50 timeout");
    events[1] = 1'b1;
    tick();
    applyStimulus("WTFT", "1", "50");
    for (int k = 0; k < 49; k++) tick();
    checkOutput("wtft_pre_noack", ack, 0);
    checkOutput("wtft_pre_noto", timeout_err, 0);
    tick();
    checkOutput("wtft_to_ack", ack, 1);
    checkOutput("wtft_to_err", timeout_err, 1);
    checkOutput("wtft_to_cnt", err_cnt, 1);
    tick();
    checkOutput("wtft_to_single", timeout_err, 0);

    $display("[TB] WTFT 1 50 edge");
    applyStimulus("WTFT", "1", "50");
    for (int k = 0; k < 19; k++) tick();
    events[1] = 1'b0;
    tick();
    checkOutput("wtft_edge_ack", ack, 1);
    checkOutput("wtft_edge_noto", timeout_err, 0);
    checkOutput("wtft_edge_cnt", err_cnt, 1);
    tick();

    applyStimulus("WTRT", "0", "0");
    checkOutput("wtrt0_noack1", ack, 0);
    tick();
    checkOutput("wtrt0_ack", ack, 1);
    checkOutput("wtrt0_to", timeout_err, 1);
    checkOutput("wtrt0_cnt", err_cnt, 2);
    tick();

    applyStimulus("WTRT", "0", "0");
    events[0] = 1'b1;
    tick();
    checkOutput("wtrt0e_ack", ack, 1);
    checkOutput("wtrt0e_noto", timeout_err, 0);
    checkOutput("wtrt0e_cnt", err_cnt, 2);
    events[0] = 1'b0;
    tick();

    $display("[TB] unknown and no-op commands");
    applyStimulus("FOO", "1", "2");
    checkOutput("foo_ack", ack, 1);
    checkOutput("foo_unk", unknown_cmd, 1);
    checkOutput("foo_cnt", err_cnt, 3);
    tick();
    checkOutput("foo_unk_single", unknown_cmd, 0);
    applyStimulus("WTR", "9", "");
    checkOutput("wtr9_ack", ack, 1);
    checkOutput("wtr9_unk", unknown_cmd, 1);
    checkOutput("wtr9_cnt", err_cnt, 4);
    tick();
    applyStimulus("", "", "");
    checkOutput("blank_ack", ack, 1);
    checkOutput("blank_unk", unknown_cmd, 0);
    tick();
    applyStimulus("END_TEST", "", "");
    checkOutput("end_ack", ack, 1);
    checkOutput("end_unk", unknown_cmd, 0);
    checkOutput("end_cnt", err_cnt, 4);
    tick();
    applyStimulus("nop", "", "");
    checkOutput("case_unk", unknown_cmd, 1);
    checkOutput("case_cnt", err_cnt, 5);
    tick();

    $display("[TB] WAIT_CLK 100 with reset");
    applyStimulus("WAIT_CLK", "100", "");
    for (int k = 0; k < 8; k++) tick();
    applyStimulus("NOP", "", "");
    checkOutput("inject_noack", ack, 0);
    checkOutput("inject_busy", busy, 1);
    for (int k = 0; k < 29; k++) tick();
    checkOutput("prerst_busy", busy, 1);
    checkOutput("prerst_noack", ack, 0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_err", err_cnt, 0);
    tick();
    tick();
    checkOutput("midrst_noack", ack, 0);
    rst = 1'b0;
    tick();
    checkOutput("reboot_ack", ack, 1);
    tick();
    checkOutput("reboot_single", ack, 0);
    checkOutput("reboot_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
